// File: rtl/fifo_pkg.sv
// Shared constants for the switch queue FIFOs (main FIFO, VC0/VC1, D0/D1).
// Provides the default word and pointer widths, the derived depth and the
// bit positions each queue occupies in the FIFO_empties/FIFO_errors vectors.
package fifo_pkg;

   localparam int DATA_WIDTH_DEF = 6;
   localparam int ADDR_WIDTH_DEF = 2;
   localparam int DEPTH_DEF      = 1 << ADDR_WIDTH_DEF;

   // Number of queues whose status bits the flow-control machine collects
   localparam int NUM_FIFOS = 5;

   // Bit index of each queue inside FIFO_empties[4:0] / FIFO_errors[4:0]
   typedef enum logic [2:0] {
      IDX_MF  = 3'd0,
      IDX_VC0 = 3'd1,
      IDX_VC1 = 3'd2,
      IDX_D0  = 3'd3,
      IDX_D1  = 3'd4
   } fifoIdx_e;

   // Depth of a FIFO built with the given pointer width
   function automatic int fifoDepth(input int addrWidth);
      return 1 << addrWidth;
   endfunction

endpackage

// File: rtl/mem_fifo.sv
// Storage array for fifo_umbral: DEPTH x DATA_WIDTH registers with a
// synchronous write port and a registered read port. The read register is
// cleared by reset so the popped-word output starts at zero; the array
// itself is never cleared.
module mem_fifo
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_en_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   localparam int DEPTH = fifoDepth(ADDR_WIDTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rdData_q;

   // Write the incoming word into the addressed slot on an accepted push
   always_ff @(posedge clk) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Capture the addressed slot on an accepted pop; holds otherwise. When a
   // write and read hit the same slot, the old word is read out.
   always_ff @(posedge clk) begin
      if (reset) begin
         rdData_q <= '0;
      end else if (rd_en_i) begin
         rdData_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rdData_q;

endmodule

// File: rtl/fifo_umbral.sv
// Synchronous FIFO with programmable high/low watermarks, one per switch
// queue. Produces empty/full/watermark status and the error bit that the
// flow-control machine gathers. Thresholds are live inputs, not latched.
// Optional macro FIFO_ERROR_STICKY_EN: when defined, fifo_error stays high
// from the first rejected access until reset instead of pulsing.
module fifo_umbral
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_enable,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  rd_enable,
   input  logic [1:0]            Umbral_alto,
   input  logic [1:0]            Umbral_bajo,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid_out,
   output logic                  fifo_empty,
   output logic                  fifo_full,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  fifo_error,
   output logic [ADDR_WIDTH:0]   count
);

   localparam int DEPTH = fifoDepth(ADDR_WIDTH);
   localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

   logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
   logic [ADDR_WIDTH-1:0] rdPtr_q, rdPtr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic                  valid_q, valid_d;
   logic                  error_q, error_d;

   logic                  isEmpty;
   logic                  isFull;
   logic                  pushOk;
   logic                  popOk;
   logic                  reject;
   logic [ADDR_WIDTH:0]   altoExt;
   logic [ADDR_WIDTH:0]   bajoExt;

   // Accept/reject decisions: a push into a full FIFO is allowed only when a
   // pop frees a slot in the same cycle; a pop from empty is always refused
   always_comb begin
      isEmpty = (count_q == '0);
      isFull  = (count_q == DEPTH_CNT);
      pushOk  = wr_enable && (!isFull || rd_enable);
      popOk   = rd_enable && !isEmpty;
      reject  = (wr_enable && !pushOk) || (rd_enable && !popOk);
   end

   // Next-state for pointers, occupancy, read-valid and error flag
   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      valid_d = popOk;
      if (pushOk) begin
         wrPtr_d = wrPtr_q + 1'b1;
      end
      if (popOk) begin
         rdPtr_d = rdPtr_q + 1'b1;
      end
      if (pushOk && !popOk) begin
         count_d = count_q + 1'b1;
      end else if (popOk && !pushOk) begin
         count_d = count_q - 1'b1;
      end
`ifdef FIFO_ERROR_STICKY_EN
      error_d = error_q | reject;
`else
      error_d = reject;
`endif
   end

   // State registers, cleared together by synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
         valid_q <= 1'b0;
         error_q <= 1'b0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
         valid_q <= valid_d;
         error_q <= error_d;
      end
   end

   mem_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) uMem (
      .clk       (clk),
      .reset     (reset),
      .wr_en_i   (pushOk && !reset),
      .wr_addr_i (wrPtr_q),
      .wr_data_i (data_in),
      .rd_en_i   (popOk),
      .rd_addr_i (rdPtr_q),
      .rd_data_o (data_out)
   );

   // Status flags straight from the registered count; a zero high watermark
   // means "only flag when completely full"
   always_comb begin
      altoExt      = (ADDR_WIDTH+1)'(Umbral_alto);
      bajoExt      = (ADDR_WIDTH+1)'(Umbral_bajo);
      fifo_empty   = isEmpty;
      fifo_full    = isFull;
      almost_full  = (Umbral_alto == 2'd0) ? isFull : (count_q >= altoExt);
      almost_empty = (count_q <= bajoExt);
   end

   assign valid_out  = valid_q;
   assign fifo_error = error_q;
   assign count      = count_q;

endmodule
